pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline stall/refresh controller for the CPU core, generalising the fixed three-register control unit to N pipeline registers. Tracks a valid bit per pipeline register and derives per-register stall/refresh from per-stage hold requests and a flush request. Manages a multi-outstanding instruction-fetch channel: credit counting, a one-entry skid slot for responses that arrive while the first register is stalled, and a drain state that discards stale responses after a flush.

---
 rtl/pipe_hazard_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/refresh controller for an N-register in-order pipe, with a
// multi-outstanding instruction-fetch channel (credits, skid slot, flush drain).
module pipe_hazard_ctrl #(
    parameter int STAGES  = 4,
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STAGES-1:0]         hold,
    input  logic                      flush_req,
    input  logic [$clog2(STAGES)-1:0] flush_stage,
    input  logic                      inst_addr_ok,
    input  logic                      inst_data_ok,
    output logic                      inst_req,
    output logic                      inst_drop,
    output logic                      skid_load,
    output logic                      r0_src_skid,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES-1:0]         stall,
    output logic [STAGES-1:0]         refresh,
    output logic                      proto_err
);

    localparam int unsigned SW  = $clog2(STAGES);
    localparam int unsigned CW1 = CNT_W + 1;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]        state, state_n;
    logic [STAGES-1:0] valid_q, valid_n;
    logic [CNT_W-1:0]  out_cnt, out_cnt_n;
    logic [CNT_W-1:0]  drop_cnt, drop_cnt_n;
    logic              skid_valid, skid_valid_n;
    logic              proto_err_q, proto_err_n;

    logic [STAGES-1:0] flushed;
    logic [STAGES-1:0] stall_c;
    logic [STAGES-1:0] refresh_c;
    logic              credit_ok;
    logic              req_c;
    logic              fire;
    logic              resp_ok;
    logic              resp_load;
    logic              drop_c;
    logic              skid_load_c;
    logic              src_skid_c;

    // Flush mask and oldest-first stall chain; invalid registers never stall
    always_comb begin
        flushed = '0;
        stall_c = '0;
        for (int i = 0; i < STAGES; i++) begin
            flushed[i] = flush_req && (SW'(i) <= flush_stage);
        end
        stall_c[STAGES-1] = valid_q[STAGES-1] & hold[STAGES-1] & ~flushed[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            stall_c[i] = valid_q[i] & (hold[i] | stall_c[i+1]) & ~flushed[i];
        end
    end

    // Next-state: fetch credits, R[0] source selection, valid bits and drain FSM
    always_comb begin
        state_n      = state;
        valid_n      = valid_q;
        out_cnt_n    = out_cnt;
        drop_cnt_n   = drop_cnt;
        skid_valid_n = skid_valid;
        proto_err_n  = proto_err_q;
        refresh_c    = '0;
        skid_load_c  = 1'b0;
        src_skid_c   = 1'b0;

        credit_ok = ({1'b0, out_cnt} + CW1'(skid_valid)) < CW1'(MAX_OUT);
        req_c     = (state == RUN) && !flush_req && credit_ok;
        fire      = req_c && inst_addr_ok;
        resp_ok   = inst_data_ok && (out_cnt != '0);
        drop_c    = (state == DRAIN) && resp_ok;
        resp_load = (state == RUN) && resp_ok && !flushed[0];

        // A response with nothing outstanding is a bus protocol violation
        if (inst_data_ok && (out_cnt == '0)) begin
            proto_err_n = 1'b1;
        end

        // Bubble behind any stalled register, and squash everything flushed
        refresh_c[0] = flushed[0];
        for (int i = 1; i < STAGES; i++) begin
            refresh_c[i] = flushed[i] | (~stall_c[i] & stall_c[i-1]);
        end

        // R[0] prefers the skid slot; a response that cannot enter R[0] goes to skid
        if (!flushed[0] && !stall_c[0]) begin
            if (skid_valid) begin
                src_skid_c  = 1'b1;
                skid_load_c = resp_load;
            end else if (!resp_load) begin
                refresh_c[0] = 1'b1;
            end
        end else if (stall_c[0] && resp_load) begin
            if (!skid_valid) begin
                skid_load_c = 1'b1;
            end else begin
                proto_err_n = 1'b1;
            end
        end

        if (src_skid_c) begin
            skid_valid_n = skid_load_c;
        end else if (skid_load_c) begin
            skid_valid_n = 1'b1;
        end
        if (flushed[0]) begin
            skid_valid_n = 1'b0;
        end

        if (refresh_c[0]) begin
            valid_n[0] = 1'b0;
        end else if (!stall_c[0]) begin
            valid_n[0] = 1'b1;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (refresh_c[i]) begin
                valid_n[i] = 1'b0;
            end else if (!stall_c[i]) begin
                valid_n[i] = valid_q[i-1];
            end
        end

        out_cnt_n = out_cnt + CNT_W'(fire) - CNT_W'(resp_ok);

        case (state)
            RUN: begin
                if (flush_req) begin
                    drop_cnt_n = out_cnt - CNT_W'(resp_ok) + CNT_W'(fire);
                    if (drop_cnt_n != '0) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (resp_ok) begin
                    drop_cnt_n = drop_cnt - CNT_W'(1);
                    if (drop_cnt == CNT_W'(1)) begin
                        state_n = RUN;
                    end
                end
            end
            default: state_n = RUN;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            valid_q     <= '0;
            out_cnt     <= '0;
            drop_cnt    <= '0;
            skid_valid  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state       <= state_n;
            valid_q     <= valid_n;
            out_cnt     <= out_cnt_n;
            drop_cnt    <= drop_cnt_n;
            skid_valid  <= skid_valid_n;
            proto_err_q <= proto_err_n;
        end
    end

    // Control outputs are forced quiet while reset is asserted
    assign inst_req    = req_c & ~rst;
    assign inst_drop   = drop_c & ~rst;
    assign skid_load   = skid_load_c & ~rst;
    assign r0_src_skid = src_skid_c & ~rst;
    assign stall       = rst ? '0 : stall_c;
    assign refresh     = rst ? '1 : refresh_c;
    assign stage_valid = valid_q;
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: fetch-bus model plus a tag scoreboard that checks
// instructions leave R[3] in issue order, with directed hazard/flush/reset cases.
module tb_pipe_hazard_ctrl;

    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [S-1:0] hold;
    logic         flush_req;
    logic [1:0]   flush_stage;
    logic         inst_addr_ok;
    logic         inst_data_ok;
    logic         inst_req;
    logic         inst_drop;
    logic         skid_load;
    logic         r0_src_skid;
    logic [S-1:0] stage_valid;
    logic [S-1:0] stall;
    logic [S-1:0] refresh;
    logic         proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    int           pend[$];
    int           exp_q[$];
    int           r_tag[S];
    logic [S-1:0] r_occ;
    int           skid_tag;
    int           next_tag;
    bit           sb_on;
    bit           resp_en;

    logic         s_req, s_drop, s_sload, s_src;
    logic [S-1:0] s_stall, s_ref;

    logic [S-1:0] fill_exp [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                   4'b1111, 4'b1111, 4'b1111, 4'b1111};

    pipe_hazard_ctrl #(.STAGES(S), .MAX_OUT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .flush_req    (flush_req),
        .flush_stage  (flush_stage),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_req     (inst_req),
        .inst_drop    (inst_drop),
        .skid_load    (skid_load),
        .r0_src_skid  (r0_src_skid),
        .stage_valid  (stage_valid),
        .stall        (stall),
        .refresh      (refresh),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, then sample outputs
    task automatic drive(input logic [S-1:0] h, input logic fr, input logic [1:0] fs,
                         input logic aok, input bit ren);
        hold         = h;
        flush_req    = fr;
        flush_stage  = fs;
        inst_addr_ok = aok;
        resp_en      = ren;
        inst_data_ok = ren && (pend.size() > 0);
        #1;
        s_req   = inst_req;
        s_drop  = inst_drop;
        s_sload = skid_load;
        s_src   = r0_src_skid;
        s_stall = stall;
        s_ref   = refresh;
    endtask

    // Clock edge: move bus and tag model using the sampled control, then settle
    task automatic advance();
        int dtag;
        int want;
        dtag = -1;
        if (inst_data_ok && (pend.size() > 0)) begin
            dtag = pend.pop_front();
        end
        @(posedge clk);
        if (s_req && inst_addr_ok) begin
            pend.push_back(next_tag);
            if (sb_on) exp_q.push_back(next_tag);
            next_tag++;
        end
        if (sb_on && r_occ[S-1] && !s_stall[S-1]) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
            check_eq("retire_tag", 32'(r_tag[S-1]), 32'(want));
        end
        for (int i = S - 1; i >= 1; i--) begin
            if (s_ref[i]) begin
                r_occ[i] = 1'b0;
            end else if (!s_stall[i]) begin
                r_occ[i] = r_occ[i-1];
                r_tag[i] = r_tag[i-1];
            end
        end
        if (s_ref[0]) begin
            r_occ[0] = 1'b0;
        end else if (!s_stall[0]) begin
            r_occ[0] = 1'b1;
            r_tag[0] = s_src ? skid_tag : dtag;
        end
        if (s_sload) skid_tag = dtag;
        @(negedge clk);
        if (sb_on) check_eq("valid_track", 32'(stage_valid), 32'(r_occ));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; hold = '0; flush_req = 1'b0; flush_stage = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; resp_en = 1'b0;
        sb_on = 1'b1; next_tag = 1; skid_tag = -1; r_occ = '0;
        for (int i = 0; i < S; i++) r_tag[i] = -1;
        #1;
        check_eq("rst_req",     32'(inst_req), 0);
        check_eq("rst_stall",   32'(stall), 0);
        check_eq("rst_refresh", 32'(refresh), 32'(4'hF));
        check_eq("rst_valid",   32'(stage_valid), 0);
        check_eq("rst_perr",    32'(proto_err), 0);
        check_eq("rst_drop",    32'(inst_drop), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Pipe fill with continuous fetch, response one cycle after fire
        for (int k = 0; k < 8; k++) begin
            drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b1);
            check_eq("fill_req", 32'(s_req), 1);
            advance();
            check_eq("fill_valid", 32'(stage_valid), 32'(fill_exp[k]));
            check_eq("fill_outstanding", 32'(pend.size() <= 2), 1);
        end

        // hold[2] for three cycles with a full pipe
        for (int k = 0; k < 3; k++) begin
            drive(4'b0100, 1'b0, 2'd0, 1'b1, k == 0);
            check_eq("hold_stall",   32'(s_stall), 32'(4'b0111));
            check_eq("hold_refresh", 32'(s_ref),   32'(4'b1000));
            if (k == 0) check_eq("hold_skid_load", 32'(s_sload), 1);
            if (k == 1) check_eq("hold_req_gated", 32'(s_req), 0);
            advance();
            if (k == 0) check_eq("hold_valid", 32'(stage_valid), 32'(4'b0111));
        end
        drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b1);
        check_eq("release_src_skid", 32'(s_src), 1);
        advance();
        check_eq("release_valid", 32'(stage_valid), 32'(4'b1111));
        for (int k = 0; k < 6; k++) begin
            drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b1);
            advance();
        end

        // stall[0] with one response in flight: skid capture and credit gating
        drive(4'b0001, 1'b0, 2'd0, 1'b1, 1'b1);
        check_eq("s0_stall",     32'(s_stall), 32'(4'b0001));
        check_eq("s0_refresh",   32'(s_ref),   32'(4'b0010));
        check_eq("s0_skid_load", 32'(s_sload), 1);
        advance();
        drive(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("s0_req_gated", 32'(s_req), 0);
        advance();
        drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("s0_src_skid",  32'(s_src), 1);
        check_eq("s0_req_still", 32'(s_req), 0);
        advance();
        drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b1);
        check_eq("s0_src_once", 32'(s_src), 0);
        check_eq("s0_req_back", 32'(s_req), 1);
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b1);
            advance();
        end

        // Flush R[0..2] with two fetches outstanding, then drain
        drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("pre_flush_req", 32'(s_req), 1);
        advance();
        sb_on = 1'b0;
        exp_q.delete();
        drive(4'b0000, 1'b1, 2'd2, 1'b1, 1'b0);
        check_eq("flush_req_off", 32'(s_req), 0);
        check_eq("flush_stall",   32'(s_stall), 0);
        check_eq("flush_refresh", 32'(s_ref), 32'(4'b0111));
        advance();
        check_eq("flush_valid_low", 32'(stage_valid[2:0]), 0);
        for (int k = 0; k < 2; k++) begin
            drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b1);
            check_eq("drain_drop",    32'(s_drop), 1);
            check_eq("drain_req_off", 32'(s_req), 0);
            advance();
        end
        check_eq("drain_valid", 32'(stage_valid), 0);
        drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b1);
        check_eq("drain_exit_req",  32'(s_req), 1);
        check_eq("drain_exit_drop", 32'(s_drop), 0);
        advance();
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
        advance();
        check_eq("perr_clean", 32'(proto_err), 0);

        // Response with nothing outstanding
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        inst_data_ok = 1'b1;
        advance();
        check_eq("perr_set", 32'(proto_err), 1);
        drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("perr_sticky", 32'(proto_err), 1);
        check_eq("underflow_req1", 32'(s_req), 1);
        advance();
        drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("underflow_req2", 32'(s_req), 1);
        advance();
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        check_eq("underflow_full", 32'(s_req), 0);
        advance();

        // Asynchronous reset in the middle of a drain
        drive(4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
        advance();
        drive(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
        check_eq("mid_drain_drop1", 32'(s_drop), 1);
        advance();
        drive(4'b1111, 1'b0, 2'd0, 1'b0, 1'b1);
        check_eq("mid_drain_drop2", 32'(s_drop), 1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst_drop",    32'(inst_drop), 0);
        check_eq("arst_req",     32'(inst_req), 0);
        check_eq("arst_stall",   32'(stall), 0);
        check_eq("arst_refresh", 32'(refresh), 32'(4'hF));
        check_eq("arst_valid",   32'(stage_valid), 0);
        check_eq("arst_perr",    32'(proto_err), 0);
        check_eq("arst_sload",   32'(skid_load), 0);
        inst_data_ok = 1'b0;
        pend.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("post_rst_req", 32'(s_req), 1);
        advance();
        check_eq("post_rst_perr", 32'(proto_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
